// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle RV32I control unit and its decoder.
// ALU opcode values here are the ones the ALU implements; keep them in sync.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_MULDIV,
    S_TRAP
  } cu_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_IMEM_TO = 2'b10,
    FC_DMEM_TO = 2'b11
  } fault_cause_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] FN3_ADD  = 3'b000;
  localparam logic [2:0] FN3_SLL  = 3'b001;
  localparam logic [2:0] FN3_SLT  = 3'b010;
  localparam logic [2:0] FN3_SLTU = 3'b011;
  localparam logic [2:0] FN3_XOR  = 3'b100;
  localparam logic [2:0] FN3_SR   = 3'b101;
  localparam logic [2:0] FN3_OR   = 3'b110;
  localparam logic [2:0] FN3_AND  = 3'b111;

  localparam logic [6:0] FN7_BASE   = 7'b0000000;
  localparam logic [6:0] FN7_ALT    = 7'b0100000;
  localparam logic [6:0] FN7_MULDIV = 7'b0000001;

  localparam logic [1:0] RF_WDATA_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_WDATA_SEL_DM  = 2'd1;
  localparam logic [1:0] RF_WDATA_SEL_PC4 = 2'd2;

  localparam logic ALU_OP1_SEL_RS1 = 1'b0;
  localparam logic ALU_OP1_SEL_PC  = 1'b1;
  localparam logic ALU_OP2_SEL_RS2 = 1'b0;
  localparam logic ALU_OP2_SEL_IMM = 1'b1;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_SLL    = 4'h2;
  localparam logic [3:0] ALU_SLT    = 4'h3;
  localparam logic [3:0] ALU_SLTU   = 4'h4;
  localparam logic [3:0] ALU_XOR    = 4'h5;
  localparam logic [3:0] ALU_SRL    = 4'h6;
  localparam logic [3:0] ALU_SRA    = 4'h7;
  localparam logic [3:0] ALU_OR     = 4'h8;
  localparam logic [3:0] ALU_AND    = 4'h9;
  localparam logic [3:0] ALU_COPY_B = 4'hA;
  // The mul/div unit picks its variant from funct3; the ALU only forwards its result.
  localparam logic [3:0] ALU_MULDIV = 4'hB;

  typedef struct packed {
    logic       legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_muldiv;
    logic       rf_we;
    logic [1:0] wdata_sel;
    logic       op1_sel;
    logic       op2_sel;
    logic [3:0] alu_op;
    logic [2:0] branch_cond;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } dec_t;

  // funct7[5] means SRA for both OP and OP-IMM, but SUB only for register OP.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] fn3,
                                                  input logic       alt,
                                                  input logic       is_reg_op);
    case (fn3)
      FN3_ADD:  return (is_reg_op && alt) ? ALU_SUB : ALU_ADD;
      FN3_SLL:  return ALU_SLL;
      FN3_SLT:  return ALU_SLT;
      FN3_SLTU: return ALU_SLTU;
      FN3_XOR:  return ALU_XOR;
      FN3_SR:   return alt ? ALU_SRA : ALU_SRL;
      FN3_OR:   return ALU_OR;
      default:  return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational RV32I decode of the latched IR into datapath selects and a legal flag.
// CU_MULDIV_EN makes OP with funct7=0000001 legal as RV32M; otherwise it is illegal.
module rv32i_decoder
  import cu_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [6:0] opc;
  logic [2:0] fn3;
  logic [6:0] fn7;

  assign opc = ir_i[6:0];
  assign fn3 = ir_i[14:12];
  assign fn7 = ir_i[31:25];

  always_comb begin
    dec_o             = '0;
    dec_o.rs1         = ir_i[19:15];
    dec_o.rs2         = ir_i[24:20];
    dec_o.rd          = ir_i[11:7];
    dec_o.alu_op      = ALU_ADD;
    dec_o.op1_sel     = ALU_OP1_SEL_RS1;
    dec_o.op2_sel     = ALU_OP2_SEL_RS2;
    dec_o.wdata_sel   = RF_WDATA_SEL_ALU;
    dec_o.branch_cond = 3'b000;
    case (opc)
      OPC_LUI: begin
        dec_o.legal   = 1'b1;
        dec_o.rf_we   = 1'b1;
        dec_o.op2_sel = ALU_OP2_SEL_IMM;
        dec_o.alu_op  = ALU_COPY_B;
      end
      OPC_AUIPC: begin
        dec_o.legal   = 1'b1;
        dec_o.rf_we   = 1'b1;
        dec_o.op1_sel = ALU_OP1_SEL_PC;
        dec_o.op2_sel = ALU_OP2_SEL_IMM;
      end
      OPC_JAL: begin
        dec_o.legal     = 1'b1;
        dec_o.is_jump   = 1'b1;
        dec_o.rf_we     = 1'b1;
        dec_o.op1_sel   = ALU_OP1_SEL_PC;
        dec_o.op2_sel   = ALU_OP2_SEL_IMM;
        dec_o.wdata_sel = RF_WDATA_SEL_PC4;
      end
      OPC_JALR: begin
        dec_o.legal     = 1'b1;
        dec_o.is_jump   = 1'b1;
        dec_o.rf_we     = 1'b1;
        dec_o.op2_sel   = ALU_OP2_SEL_IMM;
        dec_o.wdata_sel = RF_WDATA_SEL_PC4;
      end
      OPC_BRANCH: begin
        dec_o.legal       = 1'b1;
        dec_o.is_branch   = 1'b1;
        dec_o.alu_op      = ALU_SUB;
        dec_o.branch_cond = fn3;
      end
      OPC_LOAD: begin
        dec_o.legal     = 1'b1;
        dec_o.is_load   = 1'b1;
        dec_o.rf_we     = 1'b1;
        dec_o.op2_sel   = ALU_OP2_SEL_IMM;
        dec_o.wdata_sel = RF_WDATA_SEL_DM;
      end
      OPC_STORE: begin
        dec_o.legal    = 1'b1;
        dec_o.is_store = 1'b1;
        dec_o.op2_sel  = ALU_OP2_SEL_IMM;
      end
      OPC_OPIMM: begin
        dec_o.legal   = 1'b1;
        dec_o.rf_we   = 1'b1;
        dec_o.op2_sel = ALU_OP2_SEL_IMM;
        dec_o.alu_op  = alu_from_funct3(fn3, fn7[5], 1'b0);
      end
      OPC_OP: begin
        dec_o.rf_we = 1'b1;
        if (fn7 == FN7_MULDIV) begin
`ifdef CU_MULDIV_EN
          dec_o.legal     = 1'b1;
          dec_o.is_muldiv = 1'b1;
          dec_o.alu_op    = ALU_MULDIV;
`else
          dec_o.legal     = 1'b0;
`endif
        end else begin
          dec_o.legal  = 1'b1;
          dec_o.alu_op = alu_from_funct3(fn3, fn7[5], 1'b1);
        end
      end
      default: dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK, 4 cycles (5 for loads/stores) with
// zero-wait memory; stalls on imem/dmem ready with a MEM_TIMEOUT trap. CU_MULDIV_EN adds the MULDIV state.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter bit WB_SKIP_X0  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        DM_read,
  output logic        DM_wen,
  output logic        pc_we,
  output logic [4:0]  RF_rsel1,
  output logic [4:0]  RF_rsel2,
  output logic [4:0]  RF_wsel,
  output logic        RF_wen,
  output logic [1:0]  RF_wdata_sel,
  output logic        ALU_OP1_SEL,
  output logic        ALU_OP2_SEL,
  output logic [3:0]  ALU_Operation,
  output logic [2:0]  branch_condition,
  output logic        branch,
  output logic        jump,
  output logic        instret,
  output logic        fault,
`ifdef CU_MULDIV_EN
  output logic        md_start,
  input  logic        md_done,
`endif
  output logic [1:0]  fault_cause
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  cu_state_t    state_q, state_d;
  logic [31:0]  ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fault_cause_t cause_q, cause_d;
  dec_t         dec;

  rv32i_decoder u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= 32'h0000_0013;
      cnt_q   <= '0;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (cnt_q == TMO) begin
          state_d = S_TRAP;
          cause_d = FC_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (dec.legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          cause_d = FC_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        if (dec.is_load || dec.is_store) state_d = S_MEM;
        else if (dec.is_muldiv)          state_d = S_MULDIV;
        else                             state_d = S_WRITEBACK;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WRITEBACK;
        end else if (cnt_q == TMO) begin
          state_d = S_TRAP;
          cause_d = FC_DMEM_TO;
        end
      end
      S_MULDIV: begin
`ifdef CU_MULDIV_EN
        if (md_done) state_d = S_WRITEBACK;
`else
        state_d = S_WRITEBACK;
`endif
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // Wait counter only runs while stalled on a handshake; any state change restarts it.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
      cnt_d = cnt_q + CW'(1);
  end

`ifdef CU_MULDIV_EN
  logic md_first_q;

  always_ff @(posedge clk) begin
    if (rst) md_first_q <= 1'b0;
    else     md_first_q <= (state_q == S_EXECUTE) && (state_d == S_MULDIV);
  end

  assign md_start = !rst && (state_q == S_MULDIV) && md_first_q;
`endif

  logic rsel_en, alu_en, pcsel_en, wb_en;

  always_comb begin
    rsel_en  = 1'b0;
    alu_en   = 1'b0;
    pcsel_en = 1'b0;
    wb_en    = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    DM_read  = 1'b0;
    DM_wen   = 1'b0;
    fault    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH:  imem_req = 1'b1;
        S_DECODE: rsel_en  = 1'b1;
        S_EXECUTE: begin
          rsel_en  = 1'b1;
          alu_en   = 1'b1;
          pcsel_en = 1'b1;
        end
        S_MEM: begin
          rsel_en  = 1'b1;
          alu_en   = 1'b1;
          dmem_req = 1'b1;
          DM_read  = dec.is_load;
          DM_wen   = dec.is_store;
        end
        S_MULDIV: begin
          rsel_en = 1'b1;
          alu_en  = 1'b1;
        end
        S_WRITEBACK: begin
          alu_en   = 1'b1;
          pcsel_en = 1'b1;
          wb_en    = 1'b1;
        end
        S_TRAP:  fault = 1'b1;
        default: fault = 1'b0;
      endcase
    end
  end

  assign RF_rsel1         = rsel_en ? dec.rs1 : 5'd0;
  assign RF_rsel2         = rsel_en ? dec.rs2 : 5'd0;
  assign ALU_Operation    = alu_en ? dec.alu_op : ALU_ADD;
  assign ALU_OP1_SEL      = alu_en & dec.op1_sel;
  assign ALU_OP2_SEL      = alu_en & dec.op2_sel;
  assign branch           = pcsel_en & dec.is_branch;
  assign jump             = pcsel_en & dec.is_jump;
  assign branch_condition = pcsel_en ? dec.branch_cond : 3'b000;

  assign pc_we        = wb_en;
  assign instret      = wb_en;
  assign RF_wsel      = wb_en ? dec.rd : 5'd0;
  assign RF_wdata_sel = wb_en ? dec.wdata_sel : RF_WDATA_SEL_ALU;
  assign RF_wen       = wb_en && dec.rf_we && !(WB_SKIP_X0 && (dec.rd == 5'd0));

  assign fault_cause = rst ? 2'b00 : cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=8, WB_SKIP_X0=1).
// Inputs change 1 time unit after the rising edge; outputs are checked in that same cycle.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] imem_rdata;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_req, DM_read, DM_wen, pc_we;
  logic [4:0]  RF_rsel1, RF_rsel2, RF_wsel;
  logic        RF_wen;
  logic [1:0]  RF_wdata_sel;
  logic        ALU_OP1_SEL, ALU_OP2_SEL;
  logic [3:0]  ALU_Operation;
  logic [2:0]  branch_condition;
  logic        branch, jump, instret, fault;
  logic [1:0]  fault_cause;
`ifdef CU_MULDIV_EN
  logic        md_start, md_done;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_unit #(.MEM_TIMEOUT(8), .WB_SKIP_X0(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .imem_req         (imem_req),
    .dmem_req         (dmem_req),
    .DM_read          (DM_read),
    .DM_wen           (DM_wen),
    .pc_we            (pc_we),
    .RF_rsel1         (RF_rsel1),
    .RF_rsel2         (RF_rsel2),
    .RF_wsel          (RF_wsel),
    .RF_wen           (RF_wen),
    .RF_wdata_sel     (RF_wdata_sel),
    .ALU_OP1_SEL      (ALU_OP1_SEL),
    .ALU_OP2_SEL      (ALU_OP2_SEL),
    .ALU_Operation    (ALU_Operation),
    .branch_condition (branch_condition),
    .branch           (branch),
    .jump             (jump),
    .instret          (instret),
    .fault            (fault),
`ifdef CU_MULDIV_EN
    .md_start         (md_start),
    .md_done          (md_done),
`endif
    .fault_cause      (fault_cause)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in a FETCH cycle; returns in the DECODE cycle.
  task automatic fetch(input logic [31:0] ins);
    chk("fetch_imem_req", imem_req, 1);
    imem_ready = 1'b1;
    imem_rdata = ins;
    cyc(1);
    imem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_rdata = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
`ifdef CU_MULDIV_EN
    md_done    = 1'b0;
`endif
    cyc(2);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_rf_wen", RF_wen, 0);
    rst = 1'b0;
    #1;

    // ADDI x1,x0,5
    fetch(32'h0050_0093);
    chk("addi_dec_rs1", RF_rsel1, 0);
    chk("addi_dec_rs2", RF_rsel2, 5);
    chk("addi_dec_ireq", imem_req, 0);
    cyc(1);
    chk("addi_ex_aluop", ALU_Operation, 0);
    chk("addi_ex_op2", ALU_OP2_SEL, 1);
    chk("addi_ex_op1", ALU_OP1_SEL, 0);
    chk("addi_ex_instret", instret, 0);
    cyc(1);
    chk("addi_wb_wen", RF_wen, 1);
    chk("addi_wb_wsel", RF_wsel, 1);
    chk("addi_wb_instret", instret, 1);
    chk("addi_wb_pcwe", pc_we, 1);
    chk("addi_wb_wdsel", RF_wdata_sel, 0);
    cyc(1);
    chk("addi_next_ireq", imem_req, 1);
    chk("addi_next_instret", instret, 0);

    // LW x2,0(x1), data ready on the third MEM cycle
    fetch(32'h0000_A103);
    chk("lw_dec_rs1", RF_rsel1, 1);
    cyc(1);
    chk("lw_ex_op2", ALU_OP2_SEL, 1);
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_dreq", dmem_req, 1);
      chk("lw_mem_read", DM_read, 1);
      chk("lw_mem_wen", DM_wen, 0);
      chk("lw_mem_instret", instret, 0);
      if (i == 2) dmem_ready = 1'b1;
      cyc(1);
    end
    dmem_ready = 1'b0;
    chk("lw_wb_dreq", dmem_req, 0);
    chk("lw_wb_instret", instret, 1);
    chk("lw_wb_wdsel", RF_wdata_sel, 1);
    chk("lw_wb_wen", RF_wen, 1);
    chk("lw_wb_wsel", RF_wsel, 2);
    cyc(1);

    // SW x2,4(x1), zero-wait
    fetch(32'h0020_A223);
    cyc(2);
    chk("sw_mem_wen", DM_wen, 1);
    chk("sw_mem_read", DM_read, 0);
    chk("sw_mem_dreq", dmem_req, 1);
    dmem_ready = 1'b1;
    cyc(1);
    dmem_ready = 1'b0;
    chk("sw_wb_rfwen", RF_wen, 0);
    chk("sw_wb_pcwe", pc_we, 1);
    cyc(1);

    // BEQ x1,x2,8
    fetch(32'h0020_8463);
    cyc(1);
    chk("beq_ex_branch", branch, 1);
    chk("beq_ex_jump", jump, 0);
    chk("beq_ex_cond", branch_condition, 0);
    chk("beq_ex_aluop", ALU_Operation, 1);
    cyc(1);
    chk("beq_wb_rfwen", RF_wen, 0);
    chk("beq_wb_branch", branch, 1);
    chk("beq_wb_instret", instret, 1);
    cyc(1);

    // BNE x1,x2,8
    fetch(32'h0020_9463);
    cyc(1);
    chk("bne_ex_cond", branch_condition, 1);
    cyc(2);

    // JAL x1,8
    fetch(32'h0080_00EF);
    cyc(1);
    chk("jal_ex_jump", jump, 1);
    chk("jal_ex_op1", ALU_OP1_SEL, 1);
    chk("jal_ex_cond", branch_condition, 0);
    cyc(1);
    chk("jal_wb_wdsel", RF_wdata_sel, 2);
    chk("jal_wb_wen", RF_wen, 1);
    chk("jal_wb_jump", jump, 1);
    cyc(1);

    // SUB x3,x1,x2 and SRAI x1,x1,2
    fetch(32'h4020_81B3);
    cyc(1);
    chk("sub_ex_aluop", ALU_Operation, 1);
    chk("sub_ex_op2", ALU_OP2_SEL, 0);
    cyc(2);
    fetch(32'h4020_D093);
    cyc(1);
    chk("srai_ex_aluop", ALU_Operation, 7);
    cyc(2);

    // ADDI x0,x0,0: no register write, PC still advances
    fetch(32'h0000_0013);
    cyc(2);
    chk("nop_wb_rfwen", RF_wen, 0);
    chk("nop_wb_pcwe", pc_we, 1);
    chk("nop_wb_instret", instret, 1);
    cyc(1);

    // All-zero word is illegal; trap is sticky until reset
    fetch(32'h0000_0000);
    cyc(1);
    chk("ill_fault", fault, 1);
    chk("ill_cause", fault_cause, 1);
    chk("ill_ireq", imem_req, 0);
    chk("ill_pcwe", pc_we, 0);
    cyc(3);
    chk("ill_sticky", fault, 1);
    chk("ill_sticky_ireq", imem_req, 0);
    rst = 1'b1;
    cyc(1);
    chk("ill_rst_fault", fault, 0);
    chk("ill_rst_cause", fault_cause, 0);
    rst = 1'b0;
    #1;
    chk("ill_rst_ireq", imem_req, 1);

`ifdef CU_MULDIV_EN
    // MUL x3,x1,x2 through the mul/div handshake
    fetch(32'h0220_81B3);
    cyc(2);
    chk("mul_start", md_start, 1);
    chk("mul_instret0", instret, 0);
    cyc(1);
    chk("mul_start_pulse", md_start, 0);
    chk("mul_wait_wen", RF_wen, 0);
    cyc(1);
    chk("mul_wait_instret", instret, 0);
    md_done = 1'b1;
    cyc(1);
    md_done = 1'b0;
    chk("mul_wb_wen", RF_wen, 1);
    chk("mul_wb_wsel", RF_wsel, 3);
    chk("mul_wb_wdsel", RF_wdata_sel, 0);
    cyc(1);
`else
    // MUL encoding is illegal without the mul/div extension
    fetch(32'h0220_81B3);
    cyc(1);
    chk("mul_ill_fault", fault, 1);
    chk("mul_ill_cause", fault_cause, 1);
    do_reset();
`endif

    // imem never ready: trap after 9 FETCH cycles
    do_reset();
    cyc(8);
    chk("ito_c9_ireq", imem_req, 1);
    chk("ito_c9_fault", fault, 0);
    cyc(1);
    chk("ito_fault", fault, 1);
    chk("ito_cause", fault_cause, 2);
    chk("ito_ireq", imem_req, 0);
    do_reset();

    // ready on the 9th FETCH cycle wins over the timeout
    cyc(8);
    fetch(32'h0050_0093);
    chk("ilate_fault", fault, 0);
    chk("ilate_rs2", RF_rsel2, 5);
    cyc(3);
    chk("ilate_next_ireq", imem_req, 1);

    // dmem never ready: trap after 9 MEM cycles
    fetch(32'h0000_A103);
    cyc(2);
    cyc(8);
    chk("dto_c9_dreq", dmem_req, 1);
    chk("dto_c9_fault", fault, 0);
    cyc(1);
    chk("dto_fault", fault, 1);
    chk("dto_cause", fault_cause, 3);
    chk("dto_dreq", dmem_req, 0);
    do_reset();

    // reset in the middle of a data access
    fetch(32'h0000_A103);
    cyc(2);
    chk("rmem_dreq", dmem_req, 1);
    rst = 1'b1;
    cyc(1);
    chk("rmem_dreq_drop", dmem_req, 0);
    chk("rmem_read_drop", DM_read, 0);
    rst = 1'b0;
    #1;
    chk("rmem_fetch", imem_req, 1);
    chk("rmem_dreq_after", dmem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
